// File: rtl/pipe_pkg.sv
// Shared types for the decode-to-execute boundary: forwarding select codes
// and the packed E-domain control bundle.
package pipe_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic       Valid;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic       MemWrite;
    logic       Jump;
    logic       Branch;
    logic [1:0] ALUControl;
    logic       ALUSrc;
  } ctrl_e_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode/hazard logic and the ID/EX pipeline register.
// The stage is the slave; whoever drives the decode side is the master.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);

  logic              StallE, FlushE, ValidD;
  logic              RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]        ResultSrcD, ALUControlD;
  logic [DATA_W-1:0] RD1D, RD2D, PCD, PCPlus4D, ExtImmD;
  logic [REG_AW-1:0] Rs1D, Rs2D, RdD;
  logic [1:0]        ForwardAE, ForwardBE;
  logic [DATA_W-1:0] ALUResultM, ResultW;

  logic              ValidE;
  logic              RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]        ResultSrcE, ALUControlE;
  logic [DATA_W-1:0] RD1E, RD2E, PCE, PCPlus4E, ExtImmE;
  logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
  logic [DATA_W-1:0] SrcAE, WriteDataE;
  logic [CNT_W-1:0]  BubbleCnt;

  modport master (
    output StallE, FlushE, ValidD,
    output RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD,
    output RD1D, RD2D, PCD, PCPlus4D, ExtImmD, Rs1D, Rs2D, RdD,
    output ForwardAE, ForwardBE, ALUResultM, ResultW,
    input  ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
    input  RD1E, RD2E, PCE, PCPlus4E, ExtImmE, Rs1E, Rs2E, RdE,
    input  SrcAE, WriteDataE, BubbleCnt
  );

  modport slave (
    input  StallE, FlushE, ValidD,
    input  RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD,
    input  RD1D, RD2D, PCD, PCPlus4D, ExtImmD, Rs1D, Rs2D, RdD,
    input  ForwardAE, ForwardBE, ALUResultM, ResultW,
    output ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
    output RD1E, RD2E, PCE, PCPlus4E, ExtImmE, Rs1E, Rs2E, RdE,
    output SrcAE, WriteDataE, BubbleCnt
  );

endinterface

// File: rtl/fwd_mux3.sv
// Three-way operand forwarding mux: register-file value, writeback result
// or memory-stage ALU result. The reserved select falls back to the register value.
module fwd_mux3
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        i_sel,
  input  logic [DATA_W-1:0] i_reg,
  input  logic [DATA_W-1:0] i_wb,
  input  logic [DATA_W-1:0] i_mem,
  output logic [DATA_W-1:0] o_y
);

  always_comb begin
    o_y = i_reg;
    case (i_sel)
      FWD_REG: o_y = i_reg;
      FWD_WB:  o_y = i_wb;
      FWD_MEM: o_y = i_mem;
      default: o_y = i_reg;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall/flush, operand forwarding into the
// execute stage and a saturating count of inserted bubbles.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  ctrl_e_t           r_ctrl;
  ctrl_e_t           w_ctrl_d;
  logic [DATA_W-1:0] r_rd1, r_rd2, r_pc, r_pc_plus4, r_imm;
  logic [REG_AW-1:0] r_rs1, r_rs2, r_rd;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic              w_bubble;
  logic [DATA_W-1:0] w_src_a, w_write_data;

  // A non-valid decode slot carries no control, so side effects cannot leak downstream.
  always_comb begin
    w_ctrl_d = '0;
    if (bus.ValidD) begin
      w_ctrl_d.Valid      = 1'b1;
      w_ctrl_d.RegWrite   = bus.RegWriteD;
      w_ctrl_d.ResultSrc  = bus.ResultSrcD;
      w_ctrl_d.MemWrite   = bus.MemWriteD;
      w_ctrl_d.Jump       = bus.JumpD;
      w_ctrl_d.Branch     = bus.BranchD;
      w_ctrl_d.ALUControl = bus.ALUControlD;
      w_ctrl_d.ALUSrc     = bus.ALUSrcD;
    end else begin
      w_ctrl_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl     <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
    end else if (bus.FlushE) begin
      r_ctrl     <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
    end else if (!bus.StallE) begin
      r_ctrl     <= w_ctrl_d;
      r_rd1      <= bus.RD1D;
      r_rd2      <= bus.RD2D;
      r_pc       <= bus.PCD;
      r_pc_plus4 <= bus.PCPlus4D;
      r_imm      <= bus.ExtImmD;
      r_rs1      <= bus.Rs1D;
      r_rs2      <= bus.Rs2D;
      r_rd       <= bus.RdD;
    end
  end

  // A flush, or an unstalled capture of a non-valid slot, both put a bubble into E.
  assign w_bubble = bus.FlushE | (~bus.StallE & ~bus.ValidD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  fwd_mux3 #(.DATA_W(DATA_W)) u_fwd_a (
    .i_sel (bus.ForwardAE),
    .i_reg (r_rd1),
    .i_wb  (bus.ResultW),
    .i_mem (bus.ALUResultM),
    .o_y   (w_src_a)
  );

  fwd_mux3 #(.DATA_W(DATA_W)) u_fwd_b (
    .i_sel (bus.ForwardBE),
    .i_reg (r_rd2),
    .i_wb  (bus.ResultW),
    .i_mem (bus.ALUResultM),
    .o_y   (w_write_data)
  );

  assign bus.ValidE      = r_ctrl.Valid;
  assign bus.RegWriteE   = r_ctrl.RegWrite;
  assign bus.ResultSrcE  = r_ctrl.ResultSrc;
  assign bus.MemWriteE   = r_ctrl.MemWrite;
  assign bus.JumpE       = r_ctrl.Jump;
  assign bus.BranchE     = r_ctrl.Branch;
  assign bus.ALUControlE = r_ctrl.ALUControl;
  assign bus.ALUSrcE     = r_ctrl.ALUSrc;
  assign bus.RD1E        = r_rd1;
  assign bus.RD2E        = r_rd2;
  assign bus.PCE         = r_pc;
  assign bus.PCPlus4E    = r_pc_plus4;
  assign bus.ExtImmE     = r_imm;
  assign bus.Rs1E        = r_rs1;
  assign bus.Rs2E        = r_rs2;
  assign bus.RdE         = r_rd;
  assign bus.SrcAE       = w_src_a;
  assign bus.WriteDataE  = w_write_data;
  assign bus.BubbleCnt   = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed plus randomized bench for id_ex_stage against a behavioural model
// of the E slot; a second instance with a 4-bit counter covers saturation.
module tb_id_ex_stage;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) bus ();
  id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  bus4 ();

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid, regw, memw, jump, branch, alusrc;
    logic [1:0]  rsrc, aluc;
    logic [31:0] rd1, rd2, pc, pcp4, imm;
    logic [4:0]  rs1, rs2, rd;
  } e_model_t;

  e_model_t m;
  int       m_cnt;
  int       m4_cnt;
  int       saved_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] regv);
    if (sel == 2'd1) return bus.ResultW;
    else if (sel == 2'd2) return bus.ALUResultM;
    else return regv;
  endfunction

  task automatic check_all();
    chk("ValidE",      32'(bus.ValidE),      32'(m.valid));
    chk("RegWriteE",   32'(bus.RegWriteE),   32'(m.regw));
    chk("MemWriteE",   32'(bus.MemWriteE),   32'(m.memw));
    chk("JumpE",       32'(bus.JumpE),       32'(m.jump));
    chk("BranchE",     32'(bus.BranchE),     32'(m.branch));
    chk("ALUSrcE",     32'(bus.ALUSrcE),     32'(m.alusrc));
    chk("ResultSrcE",  32'(bus.ResultSrcE),  32'(m.rsrc));
    chk("ALUControlE", 32'(bus.ALUControlE), 32'(m.aluc));
    chk("RD1E",        bus.RD1E,             m.rd1);
    chk("RD2E",        bus.RD2E,             m.rd2);
    chk("PCE",         bus.PCE,              m.pc);
    chk("PCPlus4E",    bus.PCPlus4E,         m.pcp4);
    chk("ExtImmE",     bus.ExtImmE,          m.imm);
    chk("Rs1E",        32'(bus.Rs1E),        32'(m.rs1));
    chk("Rs2E",        32'(bus.Rs2E),        32'(m.rs2));
    chk("RdE",         32'(bus.RdE),         32'(m.rd));
    chk("SrcAE",       bus.SrcAE,            fwd(bus.ForwardAE, m.rd1));
    chk("WriteDataE",  bus.WriteDataE,       fwd(bus.ForwardBE, m.rd2));
    chk("BubbleCnt",   32'(bus.BubbleCnt),   32'(m_cnt));
    chk("BubbleCnt4",  32'(bus4.BubbleCnt),  32'(m4_cnt));
  endtask

  // Behavioural view of one rising edge: bubble, hold, or take the decode slot.
  task automatic model_edge();
    if (bus.FlushE) begin
      m = '0;
      if (m_cnt < 65535) m_cnt++;
    end else if (!bus.StallE) begin
      m.valid = bus.ValidD;
      m.rd1 = bus.RD1D;  m.rd2 = bus.RD2D;  m.pc = bus.PCD;
      m.pcp4 = bus.PCPlus4D;  m.imm = bus.ExtImmD;
      m.rs1 = bus.Rs1D;  m.rs2 = bus.Rs2D;  m.rd = bus.RdD;
      m.regw   = bus.ValidD & bus.RegWriteD;
      m.memw   = bus.ValidD & bus.MemWriteD;
      m.jump   = bus.ValidD & bus.JumpD;
      m.branch = bus.ValidD & bus.BranchD;
      m.alusrc = bus.ValidD & bus.ALUSrcD;
      m.rsrc   = bus.ValidD ? bus.ResultSrcD : 2'b00;
      m.aluc   = bus.ValidD ? bus.ALUControlD : 2'b00;
      if (!bus.ValidD && m_cnt < 65535) m_cnt++;
    end
    if (bus4.FlushE || (!bus4.StallE && !bus4.ValidD)) begin
      if (m4_cnt < 15) m4_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_d();
    bus.ValidD      = ($urandom_range(0, 3) != 0);
    bus.RegWriteD   = 1'($urandom);
    bus.MemWriteD   = 1'($urandom);
    bus.JumpD       = 1'($urandom);
    bus.BranchD     = 1'($urandom);
    bus.ALUSrcD     = 1'($urandom);
    bus.ResultSrcD  = 2'($urandom);
    bus.ALUControlD = 2'($urandom);
    bus.RD1D = $urandom;  bus.RD2D = $urandom;  bus.PCD = $urandom;
    bus.PCPlus4D = $urandom;  bus.ExtImmD = $urandom;
    bus.Rs1D = 5'($urandom);  bus.Rs2D = 5'($urandom);  bus.RdD = 5'($urandom);
    bus.ForwardAE = 2'($urandom);  bus.ForwardBE = 2'($urandom);
    bus.ALUResultM = $urandom;  bus.ResultW = $urandom;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m = '0;  m_cnt = 0;  m4_cnt = 0;
    rst = 1'b1;
    bus.StallE = 1'b0;  bus.FlushE = 1'b0;
    rand_d();
    bus.ValidD = 1'b0;  bus.ForwardAE = 2'b00;  bus.ForwardBE = 2'b00;
    bus4.StallE = 1'b1;  bus4.FlushE = 1'b0;  bus4.ValidD = 1'b0;
    bus4.RegWriteD = 1'b0;  bus4.MemWriteD = 1'b0;  bus4.JumpD = 1'b0;
    bus4.BranchD = 1'b0;  bus4.ALUSrcD = 1'b0;  bus4.ResultSrcD = 2'b00;
    bus4.ALUControlD = 2'b00;  bus4.RD1D = 32'd0;  bus4.RD2D = 32'd0;
    bus4.PCD = 32'd0;  bus4.PCPlus4D = 32'd0;  bus4.ExtImmD = 32'd0;
    bus4.Rs1D = 5'd0;  bus4.Rs2D = 5'd0;  bus4.RdD = 5'd0;
    bus4.ForwardAE = 2'b00;  bus4.ForwardBE = 2'b00;
    bus4.ALUResultM = 32'd0;  bus4.ResultW = 32'd0;
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Directed capture.
    rand_d();
    bus.ValidD = 1'b1;  bus.RD1D = 32'h0000_0010;  bus.RdD = 5'd5;
    bus.RegWriteD = 1'b1;  bus.ForwardAE = 2'b00;
    tick();
    chk("cap_RD1E", bus.RD1E, 32'h0000_0010);
    chk("cap_RdE", 32'(bus.RdE), 32'd5);
    chk("cap_RegWriteE", 32'(bus.RegWriteE), 32'd1);
    chk("cap_ValidE", 32'(bus.ValidE), 32'd1);
    chk("cap_SrcAE", bus.SrcAE, 32'h0000_0010);

    // Forwarding on a captured RD2E of 1.
    bus.RD2D = 32'h0000_0001;
    tick();
    bus.ALUResultM = 32'hAAAA_0000;  bus.ResultW = 32'h5555_0000;
    bus.ForwardBE = 2'b10;  #1;
    chk("fwd_mem", bus.WriteDataE, 32'hAAAA_0000);
    bus.ForwardBE = 2'b01;  #1;
    chk("fwd_wb", bus.WriteDataE, 32'h5555_0000);
    bus.ForwardBE = 2'b11;  #1;
    chk("fwd_rsv", bus.WriteDataE, 32'h0000_0001);
    bus.ForwardBE = 2'b00;  #1;
    chk("fwd_reg", bus.WriteDataE, 32'h0000_0001);

    // Stall for three cycles while decode inputs keep changing.
    saved_cnt = m_cnt;
    bus.StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_d();
      tick();
    end
    chk("stall_cnt", 32'(bus.BubbleCnt), 32'(saved_cnt));
    bus.StallE = 1'b0;
    rand_d();
    tick();

    // Flush wins over stall.
    saved_cnt = m_cnt;
    rand_d();
    bus.FlushE = 1'b1;  bus.StallE = 1'b1;  bus.MemWriteD = 1'b1;  bus.ValidD = 1'b1;
    tick();
    chk("fs_MemWriteE", 32'(bus.MemWriteE), 32'd0);
    chk("fs_ValidE", 32'(bus.ValidE), 32'd0);
    chk("fs_RD1E", bus.RD1E, 32'd0);
    chk("fs_cnt", 32'(bus.BubbleCnt), 32'(saved_cnt + 1));
    bus.FlushE = 1'b0;  bus.StallE = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      rand_d();
      bus.FlushE = ($urandom_range(0, 7) == 0);
      bus.StallE = ($urandom_range(0, 3) == 0);
      tick();
    end

    // Asynchronous reset in the middle of the low phase.
    bus.FlushE = 1'b0;  bus.StallE = 1'b0;
    rand_d();
    bus.ValidD = 1'b1;  bus.RD1D = bus.RD1D | 32'd1;
    tick();
    bus.ForwardAE = 2'b00;  bus.ForwardBE = 2'b00;
    #2;
    rst = 1'b1;
    #1;
    m = '0;  m_cnt = 0;  m4_cnt = 0;
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Saturation on the 4-bit counter instance.
    bus4.StallE = 1'b0;  bus4.ValidD = 1'b1;  bus4.FlushE = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    chk("sat4", 32'(bus4.BubbleCnt), 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline boundary, sitting directly upstream of the execute stage.
- Registers all decode-stage control and data fields into the E domain, with stall (hold) and flush (bubble insertion).
- Drives the execute stage's SrcAE and WriteDataE inputs through forwarding muxes that select between the registered read data, the memory-stage ALU result and the writeback result.
- Keeps a bubble counter for performance observation.

Parameters:
- DATA_W, 32, width of register data, PC, immediate and result buses.
- REG_AW, 5, register-index width.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- StallE  in  1  hold all E registers.
- FlushE  in  1  replace the incoming instruction with a bubble.
- ValidD  in  1  decode slot holds a real instruction.
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decode control bits.
- ResultSrcD  in  2  result-select control.
- ALUControlD  in  2  ALU operation.
- RD1D, RD2D, PCD, PCPlus4D, ExtImmD  in  DATA_W each  decode data.
- Rs1D, Rs2D, RdD  in  REG_AW each  register indices.
- ForwardAE, ForwardBE  in  2 each  forwarding selects from the hazard unit.
- ALUResultM  in  DATA_W  memory-stage ALU result.
- ResultW  in  DATA_W  writeback result.
- ValidE  out  1  E slot holds a real instruction.
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  registered control.
- ResultSrcE  out  2  registered result-select control.
- ALUControlE  out  2  registered ALU operation.
- RD1E, RD2E, PCE, PCPlus4E, ExtImmE  out  DATA_W each  registered data.
- Rs1E, Rs2E, RdE  out  REG_AW each  registered indices; Rs1E/Rs2E also go to the hazard unit.
- SrcAE  out  DATA_W  forwarded operand A.
- WriteDataE  out  DATA_W  forwarded operand B / store data.
- BubbleCnt  out  CNT_W  number of bubbles inserted since reset.

Behaviour:
- Reset (async, rst=1): every registered output goes to 0 immediately and BubbleCnt=0. The E slot is then a bubble: ValidE=0, RegWriteE=0, MemWriteE=0, JumpE=0, BranchE=0.
- Leaving reset: first capture occurs on the first rising clk edge with rst=0.
- Per-edge priority, applied when rst=0:
  1. FlushE=1: all E registers load 0, i.e. a bubble. This applies regardless of StallE; flush wins over stall.
  2. else StallE=1: all E registers hold their value.
  3. else: all E registers load their D counterparts. ValidE loads ValidD.
- Latency: 1 cycle from a D input to the matching E output.
- Bubble counter: increments by 1 on every edge where FlushE=1. It also increments when StallE=0 and ValidD=0, since the capture then loads a non-valid slot. It saturates at all-ones, with no wrap.
- Forwarding is combinational, on registered values only. No D input reaches SrcAE or WriteDataE in the same cycle.
  - ForwardAE=00 → SrcAE=RD1E
  - ForwardAE=01 → SrcAE=ResultW
  - ForwardAE=10 → SrcAE=ALUResultM
  - ForwardAE=11 → reserved; SrcAE=RD1E
  - ForwardBE selects WriteDataE from RD2E, ResultW and ALUResultM with the identical encoding.
- While ValidE=0, the control outputs must be 0 so that no architectural side effects occur downstream.
- Reset mid-operation: outputs clear asynchronously, without waiting for a clock edge. Any in-flight instruction is discarded.
- Simultaneous FlushE and StallE: a bubble is loaded, and the counter increments once.

Decomposition:
- Shared package `pipe_pkg`:
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - Packed struct type ctrl_e_t with fields RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc and Valid, so that flush clears one packed field.
- One sub-module, `fwd_mux3`: a 3-input forwarding mux with a 2-bit select and DATA_W width. It is instantiated twice, once for operand A and once for operand B.
- The register bank and the bubble counter are written inline.

Test Plan:
- Reset: assert rst mid-cycle with all D inputs at nonzero values → all outputs read 0 before the next edge; BubbleCnt=0.
- Capture: RD1D=0x0000_0010, RdD=5, RegWriteD=1, ValidD=1, no stall or flush → next edge gives RD1E=0x10, RdE=5, RegWriteE=1, ValidE=1; with ForwardAE=00, SrcAE=0x10.
- Forwarding: RD2E=0x1, ALUResultM=0xAAAA_0000, ResultW=0x5555_0000.
  - ForwardBE=10 → WriteDataE=0xAAAA_0000.
  - ForwardBE=01 → WriteDataE=0x5555_0000.
  - ForwardBE=11 → WriteDataE=0x1.
- Stall: hold StallE=1 for 3 cycles while the D inputs change every cycle → E outputs stay constant and BubbleCnt is unchanged. After release, the next edge loads the current D values.
- Flush beats stall: FlushE=1 and StallE=1 with MemWriteD=1 and ValidD=1 → MemWriteE=0, ValidE=0, all data outputs 0, BubbleCnt increments by 1.
- Counter saturation: CNT_W=4, FlushE held for 20 cycles → BubbleCnt reaches 15 and stays at 15.
